// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first, repeated N times with optional idle gaps.
// Optional even-parity bit after each repetition when SEQ_PATTERN_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
  parameter int unsigned      PAT_W       = 4,
  parameter int unsigned      REP_W       = 4,
  parameter int unsigned      GAP_CYC     = 0,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(4'b1011)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [REP_W-1:0] repeat_count,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd4;
`endif

  logic [2:0]       state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic [PAT_W-1:0] pat_sel;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             rep_end, last_rep;
  logic             seq_n, valid_n, busy_n, done_n;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      pat     <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      pat     <= pat_n;
      bit_cnt <= bit_cnt_n;
      rep_cnt <= rep_cnt_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    pat_n     = pat;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    gap_cnt_n = gap_cnt;
    rep_end   = 1'b0;
    last_rep  = 1'b0;
    pat_sel   = (pattern_in == '0) ? DEF_PATTERN : pattern_in;

    if (abort && (state != S_IDLE)) begin
      state_n   = S_IDLE;
      bit_cnt_n = '0;
      rep_cnt_n = '0;
      gap_cnt_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            pat_n     = pat_sel;
            shreg_n   = pat_sel;
            rep_cnt_n = repeat_count;
            bit_cnt_n = '0;
            state_n   = (repeat_count == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt != BIT_W'(PAT_W - 1)) begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            shreg_n   = shreg << 1;
          end else begin
            rep_cnt_n = rep_cnt - REP_W'(1);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            state_n   = S_PAR;
`else
            rep_end   = 1'b1;
            last_rep  = (rep_cnt == REP_W'(1));
`endif
          end
        end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        S_PAR: begin
          rep_end  = 1'b1;
          last_rep = (rep_cnt == '0);
        end
`endif
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            shreg_n   = pat;
            bit_cnt_n = '0;
            state_n   = S_SHIFT;
          end else begin
            gap_cnt_n = gap_cnt + GAP_W'(1);
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase

      // End of one repetition: finish, idle gap, or seamless reload
      if (rep_end) begin
        bit_cnt_n = '0;
        if (last_rep) begin
          state_n = S_DONE;
        end else if (GAP_CYC != 0) begin
          gap_cnt_n = '0;
          state_n   = S_GAP;
        end else begin
          shreg_n = pat;
          state_n = S_SHIFT;
        end
      end
    end

    seq_n   = 1'b0;
    valid_n = 1'b0;
    if (state_n == S_SHIFT) begin
      seq_n   = shreg_n[PAT_W-1];
      valid_n = 1'b1;
    end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    if (state_n == S_PAR) begin
      seq_n   = ^pat_n;
      valid_n = 1'b1;
    end
`endif
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
  end

  // Registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sequence_out <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      sequence_out <= seq_n;
      bit_valid    <= valid_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: dut0 with no gap, dut1 with a 3-cycle gap.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  localparam int PB = 1;
  localparam logic [31:0] E1_BITS = 32'b1011110111;
  localparam int E1_N = 10, E1_DONE = 11;
  localparam logic [31:0] E2_BITS = 32'b1100011000;
  localparam int E2_N = 10, E2_BUSY = 14;
  localparam logic [31:0] E3_BITS = 32'b10111;
  localparam int E3_N = 5, E3_DONE = 6;
`else
  localparam int PB = 0;
  localparam logic [31:0] E1_BITS = 32'b10111011;
  localparam int E1_N = 8, E1_DONE = 9;
  localparam logic [31:0] E2_BITS = 32'b11001100;
  localparam int E2_N = 8, E2_BUSY = 12;
  localparam logic [31:0] E3_BITS = 32'b1011;
  localparam int E3_N = 4, E3_DONE = 5;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] start_v = '0;
  logic [1:0] abort_v = '0;
  logic [3:0] pat_v [2];
  logic [3:0] rep_v [2];
  logic [1:0] seq_o, val_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  // Model state: active transfer, cycle index since accept, captured pattern and repeats
  bit         act [2];
  int         k   [2];
  logic [3:0] mp  [2];
  int         mr  [2];

  seq_pattern_gen #(.PAT_W(4), .REP_W(4), .GAP_CYC(0), .DEF_PATTERN(4'b1011)) dut0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .pattern_in(pat_v[0]), .repeat_count(rep_v[0]),
    .sequence_out(seq_o[0]), .bit_valid(val_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  seq_pattern_gen #(.PAT_W(4), .REP_W(4), .GAP_CYC(3), .DEF_PATTERN(4'b1011)) dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .pattern_in(pat_v[1]), .repeat_count(rep_v[1]),
    .sequence_out(seq_o[1]), .bit_valid(val_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  always #5 clock = ~clock;

  function automatic int gap_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  // Index of the done cycle; every earlier cycle belongs to a bit slot or a gap slot
  function automatic int span_of(input int d);
    if (mr[d] == 0) return 0;
    return mr[d] * (PAT_W + PB) + (mr[d] - 1) * gap_of(d);
  endfunction

  // Expected {sequence_out, bit_valid, busy, done}
  function automatic logic [3:0] expect_out(input int d);
    int sp, per, pos;
    if (!act[d]) return 4'b0000;
    sp = span_of(d);
    if (k[d] == sp) return 4'b0011;
    per = PAT_W + PB + gap_of(d);
    pos = k[d] % per;
    if (pos < PAT_W) return {mp[d][PAT_W-1-pos], 3'b110};
    if ((PB == 1) && (pos == PAT_W)) return {^mp[d], 3'b110};
    return 4'b0010;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) act[d] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (act[d] && abort_v[d]) begin
          act[d] = 1'b0;
        end else if (act[d]) begin
          k[d] = k[d] + 1;
          if (k[d] > span_of(d)) act[d] = 1'b0;
        end else if (start_v[d] && !abort_v[d]) begin
          act[d] = 1'b1;
          k[d]   = 0;
          mp[d]  = (pat_v[d] == 4'b0000) ? 4'b1011 : pat_v[d];
          mr[d]  = int'(rep_v[d]);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] got, exp_v;
        got   = {seq_o[d], val_o[d], busy_o[d], done_o[d]};
        exp_v = expect_out(d);
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL cycle_dut%0d at %0t: got %b expected %b", d, $time, got, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  function automatic int count_1011(input logic [31:0] bits, input int nb);
    int n = 0;
    for (int i = 0; i + 4 <= nb; i++)
      if (bits[nb-1-i -: 4] == 4'b1011) n++;
    return n;
  endfunction

  task automatic launch(input int d, input logic [3:0] p, input logic [3:0] r);
    pat_v[d]   = p;
    rep_v[d]   = r;
    start_v[d] = 1'b1;
  endtask

  // Sample one cycle after each edge until done; optional start injected while busy
  task automatic collect(input int d, input int inj, output logic [31:0] bits,
                         output int nb, output int dc, output int bc);
    bits = '0; nb = 0; dc = 0; bc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) begin
        start_v[d] = 1'b0;
        pat_v[d]   = 4'($urandom);
        rep_v[d]   = 4'($urandom);
      end
      if ((inj != 0) && (c == inj)) begin
        pat_v[d] = 4'hF; rep_v[d] = 4'd5; start_v[d] = 1'b1;
      end
      if ((inj != 0) && (c == inj + 1)) start_v[d] = 1'b0;
      if (busy_o[d]) bc++;
      if (val_o[d]) begin
        bits = {bits[30:0], seq_o[d]};
        nb++;
      end
      if (done_o[d]) begin
        dc = c;
        break;
      end
    end
    if (dc == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] bits;
    int nb, dc, bc, done_seen;
    for (int d = 0; d < 2; d++) begin
      pat_v[d] = '0; rep_v[d] = '0; act[d] = 1'b0; k[d] = 0; mp[d] = '0; mr[d] = 0;
    end

    #2 reset = 1'b0;
    #1;
    chk("reset_out_dut0", int'({seq_o[0], val_o[0], busy_o[0], done_o[0]}), 0);
    chk("reset_out_dut1", int'({seq_o[1], val_o[1], busy_o[1], done_o[1]}), 0);
    #20;
    @(negedge clock) reset = 1'b1;
    repeat (3) @(negedge clock);

    // 1011 x2, no gap
    launch(0, 4'b1011, 4'd2);
    collect(0, 0, bits, nb, dc, bc);
    chk("t1_bits", int'(bits), int'(E1_BITS));
    chk("t1_nbits", nb, E1_N);
    chk("t1_done_cycle", dc, E1_DONE);
    chk("t1_detector_hits", count_1011(bits, nb), 2);
    repeat (2) @(negedge clock);

    // 1100 x2 with a 3-cycle gap
    launch(1, 4'b1100, 4'd2);
    collect(1, 0, bits, nb, dc, bc);
    chk("t2_bits", int'(bits), int'(E2_BITS));
    chk("t2_nbits", nb, E2_N);
    chk("t2_busy_cycles", bc, E2_BUSY);
    repeat (2) @(negedge clock);

    // all-zero pattern falls back to the default
    launch(0, 4'b0000, 4'd1);
    collect(0, 0, bits, nb, dc, bc);
    chk("t3_bits", int'(bits), int'(E3_BITS));
    chk("t3_nbits", nb, E3_N);
    chk("t3_done_cycle", dc, E3_DONE);
    repeat (2) @(negedge clock);

    // zero repeats: done right away, no bits
    launch(0, 4'b1011, 4'd0);
    collect(0, 0, bits, nb, dc, bc);
    chk("t4_nbits", nb, 0);
    chk("t4_done_cycle", dc, 1);
    repeat (2) @(negedge clock);

    // start during busy must not disturb the stream
    launch(1, 4'b1100, 4'd2);
    collect(1, 2, bits, nb, dc, bc);
    chk("t5_bits", int'(bits), int'(E2_BITS));
    chk("t5_busy_cycles", bc, E2_BUSY);
    repeat (3) @(negedge clock);
    chk("t5_idle_after", int'(busy_o[1]), 0);

    // abort on the third bit of the first repetition
    launch(0, 4'b1011, 4'd2);
    @(posedge clock); #1 start_v[0] = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("t6_third_bit", int'({seq_o[0], val_o[0]}), 3);
    abort_v[0] = 1'b1;
    @(posedge clock); #1 abort_v[0] = 1'b0;
    chk("t6_abort_idle", int'({seq_o[0], val_o[0], busy_o[0]}), 0);
    done_seen = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done_o[0]) done_seen++;
    end
    chk("t6_no_done", done_seen, 0);

    // abort together with start in idle drops the start
    @(negedge clock);
    launch(0, 4'b1011, 4'd1);
    abort_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("t7_abort_start_idle", int'(busy_o[0]), 0);
    repeat (2) @(negedge clock);

    // async reset mid-transfer
    launch(1, 4'b1100, 4'd3);
    @(posedge clock); #1 start_v[1] = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("t8_reset_dut1", int'({seq_o[1], val_o[1], busy_o[1], done_o[1]}), 0);
    @(negedge clock) reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("t8_idle_after_reset", int'(busy_o[1]), 0);

    // normal transfer after reset
    launch(0, 4'b1011, 4'd2);
    collect(0, 0, bits, nb, dc, bc);
    chk("t9_bits", int'(bits), int'(E1_BITS));
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
